// File: rtl/ps2_keyb.sv
// rtl/ps2_keyb.sv - PS/2 keyboard receiver exposed as XT/AT ports 0x60/0x64 on Wishbone with IRQ1 level output.
// Optional macro PS2_FIFO_EN replaces the single holding register with an 8-entry FIFO.
module ps2_keyb #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 2500
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wb_adr_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        ps2_clk_,
  input  logic        ps2_dat_,
  output logic        intr_o
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          unused_sel;
  assign unused_sel = ^wb_sel_i;

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic          clk_filt, dat_filt, clk_filt_d;
  logic          fall;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_};
      dat_sync <= {dat_sync[0], ps2_dat_};
    end
  end

  // A filtered line only follows the synchronizer after FILTER consecutive disagreeing samples.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_filt   <= 1'b1;
      clk_cnt    <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dat_filt <= 1'b1;
      dat_cnt  <= '0;
    end else if (dat_sync[1] == dat_filt) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FW'(FILTER - 1)) begin
      dat_filt <= dat_sync[1];
      dat_cnt  <= '0;
    end else begin
      dat_cnt <= dat_cnt + 1'b1;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit, frame_end, parity_ok;
  logic          push, set_perr, set_ferr, set_toerr;

  always_comb begin
    timeout_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT));
    frame_end   = fall && (state == ST_STOP) && !timeout_hit;
    parity_ok   = ^{shift, par_bit};
    push        = frame_end & dat_filt & parity_ok;
    set_ferr    = frame_end & ~dat_filt;
    set_perr    = frame_end & dat_filt & ~parity_ok;
    set_toerr   = timeout_hit;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else if (timeout_hit) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      if (state == ST_IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat_filt) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {dat_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_filt;
            state   <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic       rd_data, rd_stat, pop, obf, set_ovr;
  logic [7:0] head, status;
  logic       ovr, ferr, toerr, perr;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wb_ack_o <= 1'b0;
    else          wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
  end

  assign rd_data = wb_ack_o & ~wb_we_i & (wb_adr_i == 2'b00);
  assign rd_stat = wb_ack_o & ~wb_we_i & (wb_adr_i == 2'b10);
  assign pop     = rd_data & obf;

`ifdef PS2_FIFO_EN
  logic [7:0] fifo_mem [0:7];
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;
  logic       push_ok;

  assign obf     = (count != 4'd0);
  assign head    = fifo_mem[rd_ptr];
  assign set_ovr = push & ~pop & (count == 4'd8);
  assign push_ok = push & ~set_ovr;

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= shift;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {3'b000, push_ok} - {3'b000, pop};
    end
  end
`else
  logic [7:0] hold;
  logic       full;

  assign obf     = full;
  assign head    = hold;
  assign set_ovr = push & full & ~pop;

  // Pop happens before push, so a push in the pop cycle simply replaces the byte.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold <= '0;
      full <= 1'b0;
    end else if (push && !set_ovr) begin
      hold <= shift;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      toerr <= 1'b0;
      perr  <= 1'b0;
    end else begin
      ovr   <= (ovr   & ~rd_stat) | set_ovr;
      ferr  <= (ferr  & ~rd_stat) | set_ferr;
      toerr <= (toerr & ~rd_stat) | set_toerr;
      perr  <= (perr  & ~rd_stat) | set_perr;
    end
  end

  assign status = {perr, toerr, ferr, ovr, 3'b000, obf};

  always_comb begin
    wb_dat_o = 16'h0000;
    if (rd_data)      wb_dat_o = {8'h00, obf ? head : 8'h00};
    else if (rd_stat) wb_dat_o = {8'h00, status};
  end

  assign intr_o = obf;

endmodule

// File: tb/tb_ps2_keyb.sv
// tb/tb_ps2_keyb.sv - self-checking bench for ps2_keyb with a queue-based reference model.
module tb_ps2_keyb;
  localparam int TIMEOUT = 2500;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [1:0]  wb_adr_i = 2'b00;
  logic [15:0] wb_dat_o;
  logic        wb_we_i  = 1'b0;
  logic [1:0]  wb_sel_i = 2'b11;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        ps2_clk_ = 1'b1;
  logic        ps2_dat_ = 1'b1;
  logic        intr_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  int         cap;
  logic       m_ovr = 0, m_ferr = 0, m_toerr = 0, m_perr = 0;

  ps2_keyb #(.FILTER(4), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .ps2_clk_(ps2_clk_), .ps2_dat_(ps2_dat_), .intr_o(intr_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
    if (!stop)                   m_ferr = 1'b1;
    else if (^{b, par} != 1'b1)  m_perr = 1'b1;
    else if (mq.size() >= cap)   m_ovr  = 1'b1;
    else                         mq.push_back(b);
  endfunction

  function automatic logic [15:0] model_status();
    logic [7:0] s;
    s = {m_perr, m_toerr, m_ferr, m_ovr, 3'b000, (mq.size() != 0)};
    m_perr = 0; m_toerr = 0; m_ferr = 0; m_ovr = 0;
    return {8'h00, s};
  endfunction

  function automatic logic [15:0] model_data();
    if (mq.size() == 0) return 16'h0000;
    return {8'h00, mq.pop_front()};
  endfunction

  function automatic logic model_obf();
    return mq.size() != 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [15:0] d);
    int n;
    d = 16'h0000;
    wb_adr_i = a; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin wait_cyc(1); n++; end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) begin
      total++; bad++;
      $display("FAIL ack_timeout: ack=0 required=1");
    end else begin
      d = wb_dat_o;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wait_cyc(1);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int half, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2_dat_ = bits[i];
      wait_cyc(half);
      if (i == glitch_at) begin
        ps2_clk_ = 1'b0; wait_cyc(2); ps2_clk_ = 1'b1; wait_cyc(half);
      end
      ps2_clk_ = 1'b0;
      wait_cyc(half);
      ps2_clk_ = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop,
                            input int half, input int glitch_at);
    logic [10:0] f;
    f = mk_frame(b, flip, stop);
    send_bits(f, 11, half, glitch_at);
    ps2_dat_ = 1'b1;
    wait_cyc(half);
    model_frame(b, f[9], stop);
  endtask

  task automatic test_reset();
    logic [15:0] d, e;
    wb_rst_i = 1'b1;
    wait_cyc(3);
    total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got=%b exp=0", wb_ack_o); end
    total++; if (wb_dat_o !== 16'h0) begin bad++; $display("FAIL reset_dat: got=%h exp=0000", wb_dat_o); end
    total++; if (intr_o !== 1'b0) begin bad++; $display("FAIL reset_intr: got=%b exp=0", intr_o); end
    wb_rst_i = 1'b0;
    wait_cyc(2);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL reset_status: got=%h exp=%h", d, e); end
  endtask

  task automatic test_good_frame();
    logic [15:0] d, e;
    send_frame(8'h1C, 1'b0, 1'b1, 12, -1);
    total++; if (intr_o !== model_obf()) begin bad++; $display("FAIL good_intr: got=%b exp=%b", intr_o, model_obf()); end
    wb_read(2'b00, d); e = model_data();
    total++; if (d !== e) begin bad++; $display("FAIL good_data: got=%h exp=%h", d, e); end
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL good_status: got=%h exp=%h", d, e); end
    total++; if (intr_o !== 1'b0) begin bad++; $display("FAIL good_intr_clr: got=%b exp=0", intr_o); end
  endtask

  task automatic test_errors();
    logic [15:0] d, e;
    send_frame(8'h1C, 1'b1, 1'b1, 10, -1);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL perr_status: got=%h exp=%h", d, e); end
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL perr_cleared: got=%h exp=%h", d, e); end
    send_frame(8'h3C, 1'b0, 1'b0, 10, -1);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL ferr_status: got=%h exp=%h", d, e); end
  endtask

  task automatic test_timeout();
    logic [15:0] d, e;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4, 10, -1);
    ps2_dat_ = 1'b1;
    wait_cyc(TIMEOUT + 100);
    m_toerr = 1'b1;
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL timeout_status: got=%h exp=%h", d, e); end
    send_frame(8'h5A, 1'b0, 1'b1, 10, -1);
    wb_read(2'b00, d); e = model_data();
    total++; if (d !== e) begin bad++; $display("FAIL timeout_next: got=%h exp=%h", d, e); end
  endtask

  task automatic test_overrun();
    logic [15:0] d, e;
    for (int i = 0; i <= cap; i++) send_frame(8'((cap == 1) ? 8'h11 * (i + 1) : i + 1), 1'b0, 1'b1, 9, -1);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL ovr_status: got=%h exp=%h", d, e); end
    for (int i = 0; i <= cap; i++) begin
      wb_read(2'b00, d); e = model_data();
      total++; if (d !== e) begin bad++; $display("FAIL ovr_data%0d: got=%h exp=%h", i, d, e); end
    end
  endtask

  task automatic test_glitch();
    logic [15:0] d, e;
    send_frame(8'hA5, 1'b0, 1'b1, 12, 4);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL glitch_status: got=%h exp=%h", d, e); end
    wb_read(2'b00, d); e = model_data();
    total++; if (d !== e) begin bad++; $display("FAIL glitch_data: got=%h exp=%h", d, e); end
  endtask

  task automatic test_pop_push();
    logic [15:0] d, e;
    logic [10:0] f;
    send_frame(8'h42, 1'b0, 1'b1, 10, -1);
    f = mk_frame(8'h99, 1'b0, 1'b1);
    send_bits(f, 10, 10, -1);
    ps2_dat_ = 1'b1;
    wait_cyc(10);
    ps2_clk_ = 1'b0;
    wait_cyc(5);
    wb_adr_i = 2'b00; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    wait_cyc(1);
    d = wb_dat_o; e = model_data();
    total++; if (wb_ack_o !== 1'b1 || d !== e) begin bad++; $display("FAIL poppush_data: ack=%b got=%h exp=%h", wb_ack_o, d, e); end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wait_cyc(1);
    model_frame(8'h99, f[9], 1'b1);
    total++; if (intr_o !== model_obf()) begin bad++; $display("FAIL popush_intr: got=%b exp=%b", intr_o, model_obf()); end
    wait_cyc(10);
    ps2_clk_ = 1'b1;
    wait_cyc(4);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL popush_status: got=%h exp=%h", d, e); end
    wb_read(2'b00, d); e = model_data();
    total++; if (d !== e) begin bad++; $display("FAIL popush_second: got=%h exp=%h", d, e); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] d, e;
    send_frame(8'h77, 1'b0, 1'b1, 10, -1);
    send_frame(8'h77, 1'b1, 1'b1, 10, -1);
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 5, 10, -1);
    ps2_dat_ = 1'b1;
    wb_rst_i = 1'b1;
    wait_cyc(2);
    mq.delete(); m_ovr = 0; m_ferr = 0; m_toerr = 0; m_perr = 0;
    total++; if (intr_o !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 16'h0) begin
      bad++; $display("FAIL midrst_outputs: intr=%b ack=%b dat=%h exp=0", intr_o, wb_ack_o, wb_dat_o);
    end
    wb_rst_i = 1'b0;
    wait_cyc(2);
    wb_read(2'b10, d); e = model_status();
    total++; if (d !== e) begin bad++; $display("FAIL midrst_status: got=%h exp=%h", d, e); end
    send_frame(8'hF0, 1'b0, 1'b1, 10, -1);
    wb_read(2'b00, d); e = model_data();
    total++; if (d !== e) begin bad++; $display("FAIL midrst_data: got=%h exp=%h", d, e); end
  endtask

  task automatic test_random();
    logic [15:0] d, e;
    logic [7:0]  b;
    int          kind;
    for (int it = 0; it < 10; it++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
      send_frame(b, kind == 0, kind != 1, $urandom_range(8, 30), -1);
      total++; if (intr_o !== model_obf()) begin bad++; $display("FAIL rand_intr%0d: got=%b exp=%b", it, intr_o, model_obf()); end
      if ($urandom_range(0, 1) == 1) begin
        wb_read(2'b00, d); e = model_data();
        total++; if (d !== e) begin bad++; $display("FAIL rand_data%0d: got=%h exp=%h", it, d, e); end
      end else begin
        wb_read(2'b10, d); e = model_status();
        total++; if (d !== e) begin bad++; $display("FAIL rand_status%0d: got=%h exp=%h", it, d, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    wb_adr_i = 2'b01; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      if (wb_ack_o) begin
        acks++;
        total++; if (wb_dat_o !== 16'h0) begin bad++; $display("FAIL b2b_dat: got=%h exp=0000", wb_dat_o); end
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wait_cyc(1);
    total++; if (acks !== 2) begin bad++; $display("FAIL b2b_acks: got=%0d exp=2", acks); end
  endtask

  initial begin
`ifdef PS2_FIFO_EN
    cap = 8;
`else
    cap = 1;
`endif
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_overrun();
    test_glitch();
    test_pop_push();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
